// File: rtl/float_mult_pipelined.sv
// Pipelined IEEE-754 style floating-point multiplier (flush-to-zero, round to nearest even).
// Input register, unpack/classify, significand multiply, normalise/round/pack: result 3 cycles after issue.
module float_mult_pipelined #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    output logic                   out_valid,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;

    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic signed [EW-1:0] EXP_OVF = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    typedef enum logic [1:0] {
        CLS_FINITE,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_e;

    // Valid pipeline (reset) and data pipeline (not reset).
    logic v0, v1, v2;

    logic [W-1:0]          a_q, b_q;
    logic                  s1_sign;
    logic signed [EW-1:0]  s1_exp;
    logic [MAN_W:0]        s1_ma, s1_mb;
    cls_e                  s1_cls;
    logic                  s2_sign;
    logic signed [EW-1:0]  s2_exp;
    logic [PW-1:0]         s2_prod;
    cls_e                  s2_cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v0 <= in_valid;
            v1 <= v0;
            v2 <= v1;
        end
    end

    // Stage 1: unpack and classify the registered operands.
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic signed [EW-1:0] s1_exp_d;
    cls_e                 s1_cls_d;

    // NOTE: always_comb uses blocking assignments and gives every output a default
    // before any branch, so no latch can be inferred.
    always_comb begin
        ea       = a_q[W-2:MAN_W];
        eb       = b_q[W-2:MAN_W];
        fa       = a_q[MAN_W-1:0];
        fb       = b_q[MAN_W-1:0];
        zero_a   = (ea == '0);
        zero_b   = (eb == '0);
        inf_a    = (ea == EXP_ONES) && (fa == '0);
        inf_b    = (eb == EXP_ONES) && (fb == '0);
        nan_a    = (ea == EXP_ONES) && (fa != '0);
        nan_b    = (eb == EXP_ONES) && (fb != '0);
        s1_exp_d = EW'(ea) + EW'(eb) - EW'(BIAS);
        s1_cls_d = CLS_FINITE;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
            s1_cls_d = CLS_NAN;
        else if (inf_a || inf_b)
            s1_cls_d = CLS_INF;
        else if (zero_a || zero_b)
            s1_cls_d = CLS_ZERO;
    end

    // NOTE: data registers carry no reset; only the valid bits decide what reaches the output.
    always_ff @(posedge clk) begin
        a_q     <= A;
        b_q     <= B;
        s1_sign <= a_q[W-1] ^ b_q[W-1];
        s1_exp  <= s1_exp_d;
        s1_ma   <= {1'b1, fa};
        s1_mb   <= {1'b1, fb};
        s1_cls  <= s1_cls_d;
        s2_sign <= s1_sign;
        s2_exp  <= s1_exp;
        s2_prod <= PW'(s1_ma) * PW'(s1_mb);
        s2_cls  <= s1_cls;
    end

    // Stage 3: normalise, round to nearest even, renormalise, range-check, pack.
    logic [MAN_W:0]       kept;
    logic                 guard, sticky, round_up;
    logic [MAN_W+1:0]     rounded;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] exp_n, exp_f;
    logic [W-1:0]         res_d;
    logic                 ovf_d, unf_d, inv_d;

    always_comb begin
        if (s2_prod[PW-1]) begin
            kept   = s2_prod[PW-1:MAN_W+1];
            guard  = s2_prod[MAN_W];
            sticky = |s2_prod[MAN_W-1:0];
            exp_n  = s2_exp + EW'(1);
        end else begin
            kept   = s2_prod[PW-2:MAN_W];
            guard  = s2_prod[MAN_W-1];
            sticky = |s2_prod[MAN_W-2:0];
            exp_n  = s2_exp;
        end
        round_up = guard & (sticky | kept[0]);
        rounded  = {1'b0, kept} + {{(MAN_W+1){1'b0}}, round_up};
        if (rounded[MAN_W+1]) begin
            frac  = rounded[MAN_W:1];
            exp_f = exp_n + EW'(1);
        end else begin
            frac  = rounded[MAN_W-1:0];
            exp_f = exp_n;
        end

        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inv_d = 1'b0;
        case (s2_cls)
            CLS_NAN: begin
                res_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                inv_d = 1'b1;
            end
            CLS_INF:  res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            CLS_ZERO: res_d = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (exp_f <= EXP_ZERO) begin
                    res_d = {s2_sign, {(W-1){1'b0}}};
                    unf_d = 1'b1;
                end else if (exp_f >= EXP_OVF) begin
                    res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
                    ovf_d = 1'b1;
                end else begin
                    res_d = {s2_sign, exp_f[EXP_W-1:0], frac};
                end
            end
        endcase
    end

    // Output registers are forced to zero whenever no valid result is present.
    always_ff @(posedge clk) begin
        if (rst || !v2) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            result    <= res_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
            invalid   <= inv_d;
        end
    end
endmodule

// File: tb/tb_float_mult_pipelined.sv
// Bench for float_mult_pipelined: binary32 instance checked every cycle against an exact real-product
// reference model; a binary16 instance checked against literal results.
module tb_float_mult_pipelined;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        out_valid, overflow, underflow, invalid;
    logic [31:0] result;

    logic        in_valid16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        out_valid16, overflow16, underflow16, invalid16;
    logic [15:0] result16;

    float_mult_pipelined dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
        .out_valid(out_valid), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    float_mult_pipelined #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .A(a16), .B(b16),
        .out_valid(out_valid16), .result(result16),
        .overflow(overflow16), .underflow(underflow16), .invalid(invalid16)
    );

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: {overflow, underflow, invalid, result}. Finite products are formed exactly in
    // double precision, then rounded to binary32 with ties to even and flush-to-zero.
    function automatic logic [34:0] model32(input logic [31:0] x, input logic [31:0] y);
        logic [7:0]  ex, ey;
        logic [22:0] fx, fy;
        logic        s, zx, zy, ix, iy, nx, ny;
        logic [63:0] dx, dy, pb;
        logic [24:0] kept;
        int          pe;
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0];  fy = y[22:0];
        s  = x[31] ^ y[31];
        zx = (ex == 8'd0);   zy = (ey == 8'd0);
        ix = (ex == 8'hFF) && (fx == '0);
        iy = (ey == 8'hFF) && (fy == '0);
        nx = (ex == 8'hFF) && (fx != '0);
        ny = (ey == 8'hFF) && (fy != '0);
        if (nx || ny || (ix && zy) || (zx && iy)) return {3'b001, 32'h7FC00000};
        if (ix || iy) return {3'b000, s, 8'hFF, 23'd0};
        if (zx || zy) return {3'b000, s, 31'd0};
        dx = {1'b0, 11'(int'(ex) + 896), fx, 29'd0};
        dy = {1'b0, 11'(int'(ey) + 896), fy, 29'd0};
        pb = $realtobits($bitstoreal(dx) * $bitstoreal(dy));
        pe = int'(pb[62:52]) - 1023 + 127;
        kept = {2'b01, pb[51:29]};
        if (pb[28] && ((|pb[27:0]) || kept[0])) kept = kept + 25'd1;
        if (kept[24]) begin
            kept = kept >> 1;
            pe   = pe + 1;
        end
        if (pe <= 0)   return {3'b010, s, 31'd0};
        if (pe >= 255) return {3'b100, s, 8'hFF, 23'd0};
        return {3'b000, s, pe[7:0], kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = int'($urandom_range(0, 11));
        f = 23'($urandom);
        case (k)
            0:       e = 8'd0;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
            2, 3:    e = 8'($urandom_range(1, 12));
            4, 5:    e = 8'($urandom_range(240, 254));
            6:       begin e = 8'($urandom_range(100, 154)); f = '1; end
            default: e = 8'($urandom_range(90, 164));
        endcase
        return {1'($urandom), e, f};
    endfunction

    typedef struct {
        int          due;
        logic [34:0] val;
    } exp_t;
    exp_t q[$];
    int   cyc = 0;
    bit   cmp_en = 1'b0;

    // Expected-result scoreboard: every accepted operation is due 3 edges after it is sampled.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (rst) q.delete();
        else if (in_valid) q.push_back('{due: cyc + 3, val: model32(a, b)});
    end

    initial forever begin
        logic        ev;
        logic [34:0] ex;
        @(negedge clk);
        if (cmp_en) begin
            ev = 1'b0;
            ex = '0;
            if (q.size() > 0 && q[0].due <= cyc) begin
                ev = (q[0].due == cyc);
                ex = ev ? q[0].val : 35'd0;
                void'(q.pop_front());
            end
            check("pipe32", {28'd0, out_valid, overflow, underflow, invalid, result},
                  {28'd0, ev, ex});
            check("one_flag", 64'($countones({overflow, underflow, invalid}) <= 1), 64'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] e;
    } vec_t;
    vec_t dir[8] = '{
        '{32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000}},
        '{32'hBF000000, 32'h40C00000, {3'b000, 32'hC0400000}},
        '{32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002}},
        '{32'h3F800001, 32'h3FC00000, {3'b000, 32'h3FC00002}},
        '{32'h7F000000, 32'h40000000, {3'b100, 32'h7F800000}},
        '{32'h00800000, 32'h3F000000, {3'b010, 32'h00000000}},
        '{32'h7F800000, 32'h00000000, {3'b001, 32'h7FC00000}},
        '{32'h00000001, 32'h40000000, {3'b000, 32'h00000000}}
    };

    initial begin
        // Reset with in_valid high: nothing sampled here may emerge.
        rst = 1'b1;
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h40000000;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_state", {out_valid, overflow, underflow, invalid, result}, '0);
        rst = 1'b0;
        in_valid = 1'b0;

        // Pin the model with hand-computed results, then push the same vectors back to back.
        foreach (dir[i]) check($sformatf("model_ref%0d", i), model32(dir[i].a, dir[i].b), dir[i].e);
        foreach (dir[i]) begin
            in_valid = 1'b1;
            a = dir[i].a;
            b = dir[i].b;
            @(negedge clk);
        end

        // Eight back-to-back distinct operations.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(110, 144)), 23'(i * 977 + 1)};
            @(negedge clk);
        end

        // Randomised traffic with idle gaps.
        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = rand_op();
            b = rand_op();
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during the third of three issued operations.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'h3FC00000 + 32'(i);
            b = 32'h40000000;
            rst = (i == 2);
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        in_valid = 1'b1;
        a = 32'h40400000;
        b = 32'hC0800000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);

        // binary16 instance.
        in_valid16 = 1'b1;
        a16 = 16'h3E00;
        b16 = 16'h4000;
        @(negedge clk);
        a16 = 16'h7800;
        b16 = 16'h4000;
        @(negedge clk);
        in_valid16 = 1'b0;
        a16 = '0;
        b16 = '0;
        @(negedge clk);
        check("h_idle", {out_valid16, overflow16, underflow16, invalid16, result16}, '0);
        @(negedge clk);
        check("h_basic", {out_valid16, overflow16, underflow16, invalid16, result16},
              {1'b1, 3'b000, 16'h4200});
        @(negedge clk);
        check("h_ovf", {out_valid16, overflow16, underflow16, invalid16, result16},
              {1'b1, 3'b100, 16'h7C00});
        @(negedge clk);
        check("h_after", {out_valid16, overflow16, underflow16, invalid16, result16}, '0);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        check("drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/float_mult_pipelined.md
FLOAT_MULT_PIPELINED -- requirements
Module: float_mult_pipelined

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa (fraction) width; the default pair gives IEEE-754 binary32.
REQ-003 Derived W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1 SHALL be localparams, not ports.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  A/B valid this cycle.
REQ-007 A  input  W  operand, {sign, exponent, fraction}.
REQ-008 B  input  W  operand, same format.
REQ-009 out_valid  output  1  result and flags valid this cycle.
REQ-010 result  output  W  product.
REQ-011 overflow  output  1  finite inputs, rounded magnitude exceeded max finite.
REQ-012 underflow  output  1  nonzero finite product flushed to zero.
REQ-013 invalid  output  1  NaN input, or Inf*0.

Function
REQ-014 Fixed latency of 3 cycles: inputs sampled at edge N appear on result and out_valid after edge N+3.
REQ-015 Fully pipelined, no backpressure: one new operation accepted per cycle, results in issue order.
REQ-016 Stage 1: unpack; sign = A.s XOR B.s; exp sum = eA+eB-BIAS in EXP_W+2-bit signed; classify zero/Inf/NaN; significands with hidden 1.
REQ-017 Stage 2: unsigned (MAN_W+1)x(MAN_W+1) multiply into 2*MAN_W+2-bit product.
REQ-018 Stage 3: normalise (shift right 1 and increment exponent if product MSB set); round to nearest, ties to even, using guard and sticky (OR of all lower bits); renormalise if rounding carries out; pack.
REQ-019 Subnormal inputs (exp=0, frac!=0) SHALL be treated as zero (flush-to-zero).
REQ-020 Final exponent <=0 with nonzero finite product: result = signed zero, underflow=1.
REQ-021 Final exponent >= 2^EXP_W-1: result = signed Inf, overflow=1.
REQ-022 Inf times nonzero finite or Inf: signed Inf, no flags.
REQ-023 Zero times finite: signed zero, no flags.
REQ-024 Either input NaN, or Inf*0: result = canonical quiet NaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=1.
REQ-025 At most one of overflow/underflow/invalid SHALL be set per output cycle.
REQ-026 When out_valid=0, result and all flags SHALL be 0.
REQ-027 Data registers need not be reset; the valid pipeline and the output registers SHALL be.

Reset
REQ-028 While rst=1 at a clock edge: all valid bits cleared, out_valid, result, overflow, underflow, invalid = 0.
REQ-029 Reset mid-operation discards all in-flight operations; none emerge after rst deasserts.
REQ-030 in_valid sampled during reset is ignored; the first operation accepted is at the first edge with rst=0.

Verification
REQ-031 Basic and sign: A=0x3FC00000 (1.5), B=0x40000000 (2.0) -> 0x40400000 three cycles later; A=0xBF000000, B=0x40C00000 -> 0xC0400000; no flags.
REQ-032 Rounding: 0x3F800001*0x3F800001 -> 0x3F800002; tie to even: 0x3F800001*0x3FC00000 -> 0x3FC00002.
REQ-033 Exceptions: 0x7F000000*0x40000000 -> 0x7F800000, overflow=1; 0x00800000*0x3F000000 -> 0x00000000, underflow=1; 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1; 0x00000001*0x40000000 -> 0x00000000, no flags.
REQ-034 Throughput: 8 back-to-back in_valid cycles with distinct operands -> 8 consecutive out_valid cycles, in order, each matching a real-valued reference model rounded to binary32.
REQ-035 Reset: issue 3 operations, assert rst for 1 cycle during the 3rd -> out_valid stays 0 until a new operation is issued, which appears exactly 3 cycles later.
REQ-036 Parametrisation: EXP_W=5, MAN_W=10 (binary16): 0x3E00*0x4000 -> 0x4200, and 0x7800*0x4000 -> 0x7C00 with overflow=1.
